// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: block-valid owner and miss-fill sequencer for a 32 x 16-byte instruction cache.
// On a miss it reads the whole 16-byte block from program memory, writes it to cache RAM, then marks it valid.
module icache_fill_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_cbr,
    input  logic        i_flush,
    output logic [31:0] o_valid_bits,
    output logic [4:0]  o_block_sel,
    input  logic        i_block_valid,
    output logic        o_hit_ack,
    output logic        o_bypass,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_cache_we,
    output logic [8:0]  o_cache_waddr,
    output logic [7:0]  o_cache_wdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

    state_t      r_state;
    logic [31:0] r_valid;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic        r_cache_we;
    logic [8:0]  r_cache_waddr;
    logic [7:0]  r_cache_wdata;
    logic [3:0]  r_count;
    logic [4:0]  r_blk;

    logic [15:0] w_base;
    logic [15:0] w_offset;
    logic        w_in_window;
    logic        w_idle;

    assign w_base      = i_cbr & 16'hFFF0;
    assign w_offset    = i_req_addr - w_base;
    assign w_in_window = w_offset < 16'd512;
    assign w_idle      = r_state == S_IDLE;

    assign o_block_sel   = w_offset[8:4];
    assign o_hit_ack     = w_idle && i_req && w_in_window && i_block_valid;
    assign o_bypass      = w_idle && i_req && !w_in_window;
    assign o_valid_bits  = r_valid;
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_cache_we    = r_cache_we;
    assign o_cache_waddr = r_cache_waddr;
    assign o_cache_wdata = r_cache_wdata;
    assign o_busy        = !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_cache_we    <= 1'b0;
            r_cache_waddr <= '0;
            r_cache_wdata <= '0;
            r_count       <= '0;
            r_blk         <= '0;
        end else if (i_flush) begin
            // flush beats any pending ack or commit: nothing from the aborted fill survives
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_cache_we    <= 1'b0;
            r_cache_waddr <= '0;
            r_cache_wdata <= '0;
            r_count       <= '0;
            r_blk         <= '0;
        end else begin
            r_cache_we <= 1'b0;
            case (r_state)
                S_IDLE: if (i_req && w_in_window && !i_block_valid) begin
                    r_blk      <= w_offset[8:4];
                    r_count    <= '0;
                    r_mem_addr <= w_base + {7'd0, w_offset[8:4], 4'h0};
                    r_mem_req  <= 1'b1;
                    r_state    <= S_FILL;
                end
                S_FILL: if (i_mem_ack) begin
                    r_cache_we    <= 1'b1;
                    r_cache_waddr <= {r_blk, r_count};
                    r_cache_wdata <= i_mem_rdata;
                    r_mem_addr    <= r_mem_addr + 16'd1;
                    r_count       <= r_count + 4'd1;
                    if (r_count == 4'hF) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_valid[r_blk] <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
